// File: rtl/arrow_judge.sv
`default_nettype none
// ============================================================================
// Module   : arrow_judge
// Brief    : Previews incoming arrows and grades lane presses against a
//            timing window. Optional perfect grading: ARROW_JUDGE_PERFECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module arrow_judge #(
    parameter int NUM_ARROWS = 4,
    parameter int LEAD       = 3,
    parameter int WINDOW     = 25000000,
    parameter int SCORE_W    = 16
`ifdef ARROW_JUDGE_PERFECT_EN
    ,
    parameter int PERFECT    = WINDOW / 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  beat_tick,
    input  logic                  arrow_valid,
    input  logic [3:0]            arrow_in,
    input  logic [NUM_ARROWS-1:0] btn,
    output logic [4*LEAD-1:0]     preview_flat,
    output logic [LEAD-1:0]       preview_valid,
    output logic [3:0]            target_arrow,
    output logic                  target_active,
    output logic                  hit_pulse,
    output logic                  miss_pulse,
`ifdef ARROW_JUDGE_PERFECT_EN
    output logic                  perfect_pulse,
`endif
    output logic [SCORE_W-1:0]    score,
    output logic [7:0]            combo,
    output logic [7:0]            max_combo
);

    localparam int c_CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int c_Q_W   = $clog2(LEAD + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_JUDGE = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_q [LEAD];
    logic [3:0]           w_shift [LEAD];
    logic [c_Q_W-1:0]     r_count;
    logic [c_Q_W-1:0]     w_wr_idx;
    logic [3:0]           w_arrow_mod;
    logic                 w_pop;
    logic                 w_push;
    logic [NUM_ARROWS-1:0] r_btn_q;
    logic [NUM_ARROWS-1:0] w_edge;
    logic [NUM_ARROWS-1:0] w_target_mask;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic                 w_hit;
    logic                 w_miss;
    logic                 w_load;
    logic [1:0]           w_inc;
    logic [SCORE_W:0]     w_score_sum;
    logic [7:0]           w_combo_inc;

    // ------------------------------------------------------------------
    // Preview queue: head in slot 0; a full queue pops on each beat
    // ------------------------------------------------------------------
    assign w_arrow_mod = 4'(32'(arrow_in) % NUM_ARROWS);
    assign w_pop       = beat_tick && (r_count == c_Q_W'(LEAD));
    assign w_push      = beat_tick && arrow_valid;
    assign w_wr_idx    = w_pop ? (r_count - 1'b1) : r_count;

    for (genvar gi = 0; gi < LEAD; gi++) begin : g_slot
        if (gi < LEAD - 1) begin : g_mid
            assign w_shift[gi] = r_q[gi+1];
        end else begin : g_last
            assign w_shift[gi] = '0;
        end
        assign preview_flat[4*gi +: 4] = r_q[gi];
        assign preview_valid[gi]       = (c_Q_W'(gi) < r_count);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LEAD; i++) begin
                r_q[i] <= '0;
            end
            r_count <= '0;
        end else if (beat_tick) begin
            for (int i = 0; i < LEAD; i++) begin
                if (w_push && (c_Q_W'(i) == w_wr_idx)) begin
                    r_q[i] <= w_arrow_mod;
                end else if (w_pop) begin
                    r_q[i] <= w_shift[i];
                end
            end
            r_count <= r_count - c_Q_W'(w_pop) + c_Q_W'(w_push);
        end
    end

    // ------------------------------------------------------------------
    // Judge FSM
    // ------------------------------------------------------------------
    assign w_edge        = btn & ~r_btn_q;
    assign w_target_mask = NUM_ARROWS'(1) << target_arrow;
    assign target_active = (r_state == S_JUDGE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_hit        = 1'b0;
        w_miss       = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_load       = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = S_JUDGE;
                end
            end
            S_JUDGE: begin
                // A new arrow overrides any press landing in the same cycle
                if (w_pop) begin
                    w_miss     = 1'b1;
                    w_load     = 1'b1;
                    w_cnt_next = '0;
                end else if (w_edge != '0) begin
                    w_hit        = (w_edge == w_target_mask);
                    w_miss       = (w_edge != w_target_mask);
                    w_state_next = S_IDLE;
                end else if (r_cnt == c_CNT_W'(WINDOW - 1)) begin
                    w_miss       = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Scoring
    // ------------------------------------------------------------------
`ifdef ARROW_JUDGE_PERFECT_EN
    logic w_perfect;
    assign w_perfect = w_hit && (int'(r_cnt) < PERFECT);
    assign w_inc     = w_perfect ? 2'd2 : 2'd1;
`else
    assign w_inc     = 2'd1;
`endif
    assign w_score_sum = {1'b0, score} + (SCORE_W+1)'(w_inc);
    assign w_combo_inc = (combo == 8'hFF) ? combo : combo + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_q      <= '0;
            r_cnt        <= '0;
            target_arrow <= '0;
            hit_pulse    <= 1'b0;
            miss_pulse   <= 1'b0;
            score        <= '0;
            combo        <= '0;
            max_combo    <= '0;
`ifdef ARROW_JUDGE_PERFECT_EN
            perfect_pulse <= 1'b0;
`endif
        end else begin
            r_btn_q    <= btn;
            r_cnt      <= w_cnt_next;
            hit_pulse  <= w_hit;
            miss_pulse <= w_miss;
`ifdef ARROW_JUDGE_PERFECT_EN
            perfect_pulse <= w_perfect;
`endif
            if (w_load) begin
                target_arrow <= r_q[0];
            end
            if (w_hit) begin
                score <= w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
                combo <= w_combo_inc;
                if (w_combo_inc > max_combo) begin
                    max_combo <= w_combo_inc;
                end
            end else if (w_miss) begin
                combo <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arrow_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_arrow_judge
// Brief    : Table-driven bench for arrow_judge with a pulse scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arrow_judge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        beat_tick = 1'b0;
    logic        arrow_valid = 1'b0;
    logic [3:0]  arrow_in = '0;
    logic [3:0]  btn = '0;

    logic [11:0] preview_flat;
    logic [2:0]  preview_valid;
    logic [3:0]  target_arrow;
    logic        target_active, hit_pulse, miss_pulse;
    logic [15:0] score;
    logic [7:0]  combo, max_combo;

    logic [11:0] s_preview_flat;
    logic [2:0]  s_preview_valid;
    logic [3:0]  s_target_arrow;
    logic        s_target_active, s_hit_pulse, s_miss_pulse;
    logic [1:0]  s_score;
    logic [7:0]  s_combo, s_max_combo;
`ifdef ARROW_JUDGE_PERFECT_EN
    logic        perfect_pulse, s_perfect_pulse;
`endif

    always #5 clk = ~clk;

    arrow_judge #(.NUM_ARROWS(4), .LEAD(3), .WINDOW(8), .SCORE_W(16)) dut (
        .clk(clk), .rst(rst), .beat_tick(beat_tick), .arrow_valid(arrow_valid),
        .arrow_in(arrow_in), .btn(btn), .preview_flat(preview_flat),
        .preview_valid(preview_valid), .target_arrow(target_arrow),
        .target_active(target_active), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
`ifdef ARROW_JUDGE_PERFECT_EN
        .perfect_pulse(perfect_pulse),
`endif
        .score(score), .combo(combo), .max_combo(max_combo)
    );

    // Narrow score instance: shares all stimulus, saturates after three points
    arrow_judge #(.NUM_ARROWS(4), .LEAD(3), .WINDOW(8), .SCORE_W(2)) u_sat (
        .clk(clk), .rst(rst), .beat_tick(beat_tick), .arrow_valid(arrow_valid),
        .arrow_in(arrow_in), .btn(btn), .preview_flat(s_preview_flat),
        .preview_valid(s_preview_valid), .target_arrow(s_target_arrow),
        .target_active(s_target_active), .hit_pulse(s_hit_pulse), .miss_pulse(s_miss_pulse),
`ifdef ARROW_JUDGE_PERFECT_EN
        .perfect_pulse(s_perfect_pulse),
`endif
        .score(s_score), .combo(s_combo), .max_combo(s_max_combo)
    );

    typedef struct {
        logic        beat;
        logic        valid;
        logic [3:0]  arrow;
        logic [3:0]  btn;
        logic [2:0]  pv;
        logic [3:0]  s0;
        logic        ta;
        logic [3:0]  tarr;
        logic        hit;
        logic        miss;
        logic [15:0] sc;
        logic [7:0]  co;
        logic [7:0]  mc;
    } vec_t;

    typedef struct {
        logic        hit;
        logic [15:0] sc;
        logic [7:0]  co;
        logic [7:0]  mc;
    } ev_t;

    vec_t vecs[$];
    ev_t  exp_q[$];
    ev_t  mon_e;
    int   n_tests = 0;
    int   n_fail = 0;

    function automatic vec_t mk(int b, int v, int a, int bt, int pv, int s0, int ta,
                                int tarr, int h, int m, int sc, int co, int mc);
        vec_t r;
        r.beat = 1'(b);  r.valid = 1'(v);  r.arrow = 4'(a);  r.btn = 4'(bt);
        r.pv = 3'(pv);   r.s0 = 4'(s0);    r.ta = 1'(ta);    r.tarr = 4'(tarr);
        r.hit = 1'(h);   r.miss = 1'(m);   r.sc = 16'(sc);   r.co = 8'(co);
        r.mc = 8'(mc);
        return r;
    endfunction

    function automatic ev_t mkev(logic h, logic [15:0] sc, logic [7:0] co, logic [7:0] mc);
        ev_t e;
        e.hit = h; e.sc = sc; e.co = co; e.mc = mc;
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (hit_pulse || miss_pulse) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, hit_pulse, miss_pulse}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_kind", {30'd0, hit_pulse, miss_pulse}, mon_e.hit ? 32'd2 : 32'd1);
                check("sb_score", 32'(score), 32'(mon_e.sc));
                check("sb_combo", 32'(combo), 32'(mon_e.co));
                check("sb_max_combo", 32'(max_combo), 32'(mon_e.mc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] bq[$];
        logic [3:0] tgt;
        logic [15:0] m_sc;
        logic [7:0] m_co, m_mc;

        // ---------------- reset state ----------------
        step(); step();
        check("rst_preview_valid", 32'(preview_valid), 32'd0);
        check("rst_preview_flat", 32'(preview_flat), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        rst = 1'b0;
        step();

        // Fill queue, open a window, then reset asynchronously mid-window
        for (int i = 0; i < 4; i++) begin
            beat_tick = 1'b1; arrow_valid = 1'b1; arrow_in = 4'(i);
            step();
        end
        beat_tick = 1'b0; arrow_valid = 1'b0;
        step(); step();
        check("pre_rst_active", 32'(target_active), 32'd1);
        check("pre_rst_target", 32'(target_arrow), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_active", 32'(target_active), 32'd0);
        check("async_rst_pv", 32'(preview_valid), 32'd0);
        check("async_rst_target", 32'(target_arrow), 32'd0);
        check("async_rst_pulses", {30'd0, hit_pulse, miss_pulse}, 32'd0);
        step();
        rst = 1'b0;

        // ---------------- table-driven main sequence ----------------
        //                 b v a bt  pv s0 ta tarr h m sc co mc
        vecs.push_back(mk(1,1,2,0,   1, 2, 0, 0,   0,0, 0, 0, 0));
        vecs.push_back(mk(1,1,0,0,   3, 2, 0, 0,   0,0, 0, 0, 0));
        vecs.push_back(mk(1,1,3,0,   7, 2, 0, 0,   0,0, 0, 0, 0));
        vecs.push_back(mk(1,1,1,0,   7, 0, 1, 2,   0,0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,0,0, 7, 0, 1, 2, 0,0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,4,   7, 0, 0, 2,   1,0, 1, 1, 1));
        vecs.push_back(mk(0,0,0,0,   7, 0, 0, 2,   0,0, 1, 1, 1));
        vecs.push_back(mk(1,0,0,0,   3, 3, 1, 0,   0,0, 1, 1, 1));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(0,0,0,0, 3, 3, 1, 0, 0,0, 1, 1, 1));
        vecs.push_back(mk(0,0,0,8,   3, 3, 0, 0,   0,1, 1, 0, 1));
        vecs.push_back(mk(0,0,0,0,   3, 3, 0, 0,   0,0, 1, 0, 1));
        vecs.push_back(mk(1,1,4,0,   7, 3, 0, 0,   0,0, 1, 0, 1));
        vecs.push_back(mk(1,1,0,0,   7, 1, 1, 3,   0,0, 1, 0, 1));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(0,0,0,0, 7, 1, 1, 3, 0,0, 1, 0, 1));
        vecs.push_back(mk(0,0,0,0,   7, 1, 0, 3,   0,1, 1, 0, 1));
        vecs.push_back(mk(1,1,6,0,   7, 0, 1, 1,   0,0, 1, 0, 1));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,0,0,0, 7, 0, 1, 1, 0,0, 1, 0, 1));
        vecs.push_back(mk(1,1,1,2,   7, 0, 1, 0,   0,1, 1, 0, 1));
        vecs.push_back(mk(0,0,0,0,   7, 0, 1, 0,   0,0, 1, 0, 1));
        vecs.push_back(mk(0,0,0,3,   7, 0, 0, 0,   0,1, 1, 0, 1));
        vecs.push_back(mk(0,0,0,0,   7, 0, 0, 0,   0,0, 1, 0, 1));

        foreach (vecs[i]) begin
            beat_tick   = vecs[i].beat;
            arrow_valid = vecs[i].valid;
            arrow_in    = vecs[i].arrow;
            btn         = vecs[i].btn;
            if (vecs[i].hit || vecs[i].miss)
                exp_q.push_back(mkev(vecs[i].hit, vecs[i].sc, vecs[i].co, vecs[i].mc));
            step();
            check($sformatf("v%0d_pv", i), 32'(preview_valid), 32'(vecs[i].pv));
            check($sformatf("v%0d_slot0", i), 32'(preview_flat[3:0]), 32'(vecs[i].s0));
            check($sformatf("v%0d_active", i), 32'(target_active), 32'(vecs[i].ta));
            check($sformatf("v%0d_target", i), 32'(target_arrow), 32'(vecs[i].tarr));
            check($sformatf("v%0d_pulses", i), {30'd0, hit_pulse, miss_pulse},
                  {30'd0, vecs[i].hit, vecs[i].miss});
            check($sformatf("v%0d_score", i), 32'(score), 32'(vecs[i].sc));
            check($sformatf("v%0d_combo", i), 32'(combo), 32'(vecs[i].co));
            check($sformatf("v%0d_max", i), 32'(max_combo), 32'(vecs[i].mc));
        end
        beat_tick = 1'b0; arrow_valid = 1'b0; btn = '0;
        check("sat_after_table", 32'(s_score), 32'd1);

        // ---------------- 256 consecutive hits ----------------
        bq = '{4'd0, 4'd2, 4'd1};
        m_sc = 16'd1; m_co = 8'd0; m_mc = 8'd1;
        for (int k = 0; k < 256; k++) begin
            beat_tick = 1'b1; arrow_valid = 1'b1; arrow_in = 4'(k % 4);
            tgt = bq.pop_front();
            bq.push_back(4'(k % 4));
            step();
            beat_tick = 1'b0; arrow_valid = 1'b0;
            step(); step();
            btn = 4'(1 << tgt);
            m_sc = m_sc + 16'd1;
            m_co = (m_co == 8'hFF) ? m_co : m_co + 8'd1;
            m_mc = (m_co > m_mc) ? m_co : m_mc;
            exp_q.push_back(mkev(1'b1, m_sc, m_co, m_mc));
            step();
            btn = '0;
            step();
        end
        check("combo_sat", 32'(combo), 32'd255);
        check("max_combo_sat", 32'(max_combo), 32'd255);
        check("score_after_run", 32'(score), 32'(m_sc));

        // ---------------- early hit (window counter 1) ----------------
        beat_tick = 1'b1; arrow_valid = 1'b1; arrow_in = 4'd3;
        tgt = bq.pop_front();
        bq.push_back(4'd3);
        step();
        beat_tick = 1'b0; arrow_valid = 1'b0;
        step();
        btn = 4'(1 << tgt);
`ifdef ARROW_JUDGE_PERFECT_EN
        m_sc = m_sc + 16'd2;
`else
        m_sc = m_sc + 16'd1;
`endif
        exp_q.push_back(mkev(1'b1, m_sc, 8'd255, 8'd255));
        step();
        check("early_hit_pulse", 32'(hit_pulse), 32'd1);
        check("early_hit_score", 32'(score), 32'(m_sc));
`ifdef ARROW_JUDGE_PERFECT_EN
        check("perfect_pulse_on", 32'(perfect_pulse), 32'd1);
`endif
        btn = '0;
        step();
`ifdef ARROW_JUDGE_PERFECT_EN
        check("perfect_pulse_off", 32'(perfect_pulse), 32'd0);
`endif
        check("hit_pulse_one_cycle", 32'(hit_pulse), 32'd0);

        check("score_saturated", 32'(s_score), 32'd3);
        step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arrow_judge.md
Name: arrow_judge

Overview:
- Consumer end of the arrow stream produced by the random arrow generator.
- On each metronome beat it accepts one arrow index into a short preview queue.
- When an arrow reaches the target line, it opens a timing window and grades the player's button presses as hit or miss.
- Drives score, combo and preview outputs for the display and scoring logic.

Parameters:
- NUM_ARROWS, 4, number of arrow lanes; arrow index range is 0..NUM_ARROWS-1.
- LEAD, 3, number of beats an arrow is previewed before it is judged (queue depth).
- WINDOW, 25000000, length of the judge window in clk cycles.
- SCORE_W, 16, score counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- beat_tick  in  1  one-cycle metronome strobe in the clk domain.
- arrow_valid  in  1  qualifies arrow_in on beat_tick; low means a rest beat.
- arrow_in  in  4  arrow index from the generator.
- btn  in  NUM_ARROWS  debounced, synchronised lane buttons, active-high.
- preview_flat  out  4*LEAD  queued arrow indices; slot 0 is the next to judge.
- preview_valid  out  LEAD  per-slot occupancy.
- target_arrow  out  4  arrow currently being judged.
- target_active  out  1  high while the judge window is open.
- hit_pulse  out  1  one-cycle strobe on a hit.
- miss_pulse  out  1  one-cycle strobe on a miss.
- score  out  SCORE_W  accumulated points.
- combo  out  8  consecutive hits.
- max_combo  out  8  best combo since reset.

Behaviour:
- Reset: all outputs are 0, the queue is empty, the FSM is in IDLE, and the button history register is 0. Reset is asynchronous and may occur mid-window; the open window is then discarded with no pulse.
- Queue: a FIFO of LEAD entries. On beat_tick:
  - If count==LEAD, the head is popped into the judge.
  - Then, if arrow_valid, arrow_in is pushed.
  - Push and pop in the same cycle are legal; count never exceeds LEAD.
  - A beat with arrow_valid=0 pushes nothing. The next beat then finds count<LEAD and pops nothing, which produces a rest.
  - arrow_in >= NUM_ARROWS is pushed as arrow_in mod NUM_ARROWS.
- preview outputs update in the cycle after beat_tick.
- Button edge detection: edge = btn & ~btn_q, where btn_q is btn registered every cycle.
- FSM states: IDLE, JUDGE.
  - IDLE -> JUDGE when the head is popped. target_arrow is loaded, target_active=1, and the window counter is cleared. Grading starts the cycle after entry.
  - In JUDGE with edge == (1<<target_arrow) exactly: hit_pulse=1 for one cycle, go to IDLE.
  - In JUDGE with any other nonzero edge (wrong lane, or multiple lanes including the correct one): miss_pulse=1, go to IDLE.
  - In JUDGE when the counter reaches WINDOW-1 with no edge: miss_pulse=1, go to IDLE.
  - beat_tick pops a new arrow while in JUDGE: the current arrow is missed (miss_pulse) and the new arrow is loaded in the same cycle; the FSM stays in JUDGE with the counter cleared. A button edge in that same cycle is ignored.
- Edges in IDLE are ignored.
- target_active falls in the cycle a pulse is issued, unless a new arrow was loaded.
- Hit: score += 1, saturating at all-ones; combo += 1, saturating at 255; max_combo = max(max_combo, new combo).
- Miss: combo = 0; score is unchanged.
- All counters update in the same cycle as their pulse.

Optional Feature:
- Macro: ARROW_JUDGE_PERFECT_EN.
- Defined:
  - Adds output perfect_pulse (1 bit) and parameter PERFECT (default WINDOW/4).
  - A hit with window counter < PERFECT is a perfect: perfect_pulse and hit_pulse both assert, and score += 2 (saturating).
  - Any other hit behaves as a normal hit.
- Undefined: no perfect_pulse port; every hit scores 1.

Test Plan (LEAD=3, WINDOW=8):
- Reset with queue loaded and window open -> all outputs 0, preview_valid=0, no pulse, and no pulse on the first beat_tick after release.
- Beats 1-4 with arrows 2,0,3,1 -> preview_valid shows 001/011/111 after beats 1-3. Beat 4 pops 2: target_arrow=2, target_active=1, preview slot0=0.
- Arrow 2 in window, btn=0100 edge on window cycle 3 -> hit_pulse 1 cycle, score=1, combo=1, max_combo=1, target_active=0.
- Arrow 0 in window, btn=1000 -> miss_pulse, combo=0, score unchanged. Separately, btn=0011 edge against arrow 0 -> miss.
- No press for 8 cycles -> miss_pulse at counter 7. Next beat arriving at counter 4 -> miss_pulse for the old arrow and target_arrow reloaded the same cycle.
- Force score=16'hFFFF, then hit -> score holds FFFF. 256 consecutive hits -> combo=255, max_combo=255. With ARROW_JUDGE_PERFECT_EN, a hit on counter 1 -> perfect_pulse and score += 2.
